// File: rtl/serial_adder.sv
// Digit-serial adder: adds WIDTH-bit A + B + Cin, DIGIT bits per clock, behind a start/done handshake.
// Optional signed-overflow output Ovf enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             Cout,
  output logic             Ovf
`else
  output logic             Cout
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   dres;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One digit slice: DIGIT-bit add of the operand LSBs plus the registered carry.
  assign dres = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dres[DIGIT];
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(dres[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          sum_d   = acc_d;
          cout_d  = dres[DIGIT];
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
          ovf_d   = dres[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dres[DIGIT];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: drivers push expected results and done cycles, per-instance monitors pop on done.
module tb_serial_adder;

  typedef struct {
    logic [16:0] val;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst8_p = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q8[$], q4[$], q16[$], qw[$], q2[$];

  // WIDTH=8 DIGIT=1
  logic st_8 = 0, ci_8 = 0, busy_8, done_8, cout_8;
  logic [7:0] a_8 = 0, b_8 = 0, sum_8;
  // WIDTH=4 DIGIT=1
  logic st_4 = 0, ci_4 = 0, busy_4, done_4, cout_4;
  logic [3:0] a_4 = 0, b_4 = 0, sum_4;
  // WIDTH=16 DIGIT=4
  logic st_16 = 0, ci_16 = 0, busy_16, done_16, cout_16;
  logic [15:0] a_16 = 0, b_16 = 0, sum_16;
  // WIDTH=8 DIGIT=8
  logic st_w = 0, ci_w = 0, busy_w, done_w, cout_w;
  logic [7:0] a_w = 0, b_w = 0, sum_w;
  // WIDTH=8 DIGIT=2
  logic st_2 = 0, ci_2 = 0, busy_2, done_2, cout_2;
  logic [7:0] a_2 = 0, b_2 = 0, sum_2;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_2;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d8 (
    .clk(clk), .rst(rst | rst8_p), .start(st_8), .A(a_8), .B(b_8), .Cin(ci_8),
    .busy(busy_8), .done(done_8), .Sum(sum_8), .Cout(cout_8));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u_d4 (
    .clk(clk), .rst(rst), .start(st_4), .A(a_4), .B(b_4), .Cin(ci_4),
    .busy(busy_4), .done(done_4), .Sum(sum_4), .Cout(cout_4));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d16 (
    .clk(clk), .rst(rst), .start(st_16), .A(a_16), .B(b_16), .Cin(ci_16),
    .busy(busy_16), .done(done_16), .Sum(sum_16), .Cout(cout_16));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_dw (
    .clk(clk), .rst(rst), .start(st_w), .A(a_w), .B(b_w), .Cin(ci_w),
    .busy(busy_w), .done(done_w), .Sum(sum_w), .Cout(cout_w));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(st_2), .A(a_2), .B(b_2), .Cin(ci_2),
`ifdef SERIAL_ADDER_OVF_EN
    .busy(busy_2), .done(done_2), .Sum(sum_2), .Cout(cout_2), .Ovf(ovf_2));
`else
    .busy(busy_2), .done(done_2), .Sum(sum_2), .Cout(cout_2));
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected done at cycle %0d", name, cyc);
  endtask

  // Monitors: pop one expectation per done pulse; result and exact cycle are compared.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done_8) begin
      if (q8.size() == 0) unexpected("d8");
      else begin
        e = q8.pop_front();
        chk("d8 result", {23'd0, cout_8, sum_8}, {15'd0, e.val});
        chk("d8 done cycle", cyc, e.cyc);
      end
    end
    if (done_4) begin
      if (q4.size() == 0) unexpected("d4");
      else begin
        e = q4.pop_front();
        chk("d4 result", {27'd0, cout_4, sum_4}, {15'd0, e.val});
        chk("d4 done cycle", cyc, e.cyc);
      end
    end
    if (done_16) begin
      if (q16.size() == 0) unexpected("d16");
      else begin
        e = q16.pop_front();
        chk("d16 result", {15'd0, cout_16, sum_16}, {15'd0, e.val});
        chk("d16 done cycle", cyc, e.cyc);
      end
    end
    if (done_w) begin
      if (qw.size() == 0) unexpected("dw");
      else begin
        e = qw.pop_front();
        chk("dw result", {23'd0, cout_w, sum_w}, {15'd0, e.val});
        chk("dw done cycle", cyc, e.cyc);
      end
    end
    if (done_2) begin
      if (q2.size() == 0) unexpected("d2");
      else begin
        e = q2.pop_front();
        chk("d2 result", {23'd0, cout_2, sum_2}, {15'd0, e.val});
        chk("d2 done cycle", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        chk("d2 ovf", {31'd0, ovf_2}, {31'd0, e.ovf});
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [3:0] na, nb;
    logic       nc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset d8",  {28'd0, busy_8, done_8, cout_8, sum_8[0]} | {24'd0, sum_8}, 32'd0);
    chk("reset d4",  {25'd0, busy_4, done_4, cout_4, sum_4}, 32'd0);
    chk("reset d16", {13'd0, busy_16, done_16, cout_16, sum_16}, 32'd0);
    chk("reset dw",  {21'd0, busy_w, done_w, cout_w, sum_w}, 32'd0);
    chk("reset d2",  {21'd0, busy_2, done_2, cout_2, sum_2}, 32'd0);

    // 8'hFF + 8'h01: latency 8, busy high 8 cycles
    st_8 = 1; a_8 = 8'hFF; b_8 = 8'h01; ci_8 = 0;
    @(posedge clk); #1;
    q8.push_back('{val: 17'h100, ovf: 1'b0, cyc: cyc + 8});
    @(negedge clk);
    st_8 = 0;
    busy_cnt = 0;
    repeat (10) begin
      if (busy_8) busy_cnt++;
      @(negedge clk);
    end
    chk("d8 busy cycles", busy_cnt, 8);

    // 16-bit, 4 bits per step
    st_16 = 1; a_16 = 16'h1234; b_16 = 16'hEDCC; ci_16 = 1;
    @(posedge clk); #1;
    q16.push_back('{val: 17'h10001, ovf: 1'b0, cyc: cyc + 4});
    @(negedge clk);
    st_16 = 0;
    repeat (6) @(negedge clk);

    // DIGIT = WIDTH: done one cycle after start
    st_w = 1; a_w = 8'hA5; b_w = 8'h5A; ci_w = 1;
    @(posedge clk); #1;
    qw.push_back('{val: 17'h100, ovf: 1'b0, cyc: cyc + 1});
    a_w = 8'h12; b_w = 8'h34; ci_w = 0;
    @(posedge clk); @(posedge clk); #1;
    qw.push_back('{val: 17'h046, ovf: 1'b0, cyc: cyc + 1});
    @(negedge clk);
    st_w = 0;
    repeat (4) @(negedge clk);

    // Second start while busy must be ignored
    st_8 = 1; a_8 = 8'h0F; b_8 = 8'h01; ci_8 = 0;
    @(posedge clk); #1;
    q8.push_back('{val: 17'h010, ovf: 1'b0, cyc: cyc + 8});
    @(negedge clk);
    st_8 = 0;
    repeat (2) @(negedge clk);
    st_8 = 1; a_8 = 8'h55; b_8 = 8'h11;
    repeat (3) @(negedge clk);
    st_8 = 0;
    repeat (8) @(negedge clk);
    chk("d8 sum held", {24'd0, sum_8}, 32'h10);

    // Reset three cycles into an operation aborts it
    st_8 = 1; a_8 = 8'hF0; b_8 = 8'h0F; ci_8 = 1;
    @(posedge clk);
    @(negedge clk);
    st_8 = 0;
    repeat (2) @(negedge clk);
    rst8_p = 1;
    @(negedge clk);
    rst8_p = 0;
    chk("d8 after abort", {22'd0, busy_8, done_8, cout_8, sum_8}, 32'd0);
    repeat (10) @(negedge clk);
    st_8 = 1; a_8 = 8'h3C; b_8 = 8'h0A; ci_8 = 1;
    @(posedge clk); #1;
    q8.push_back('{val: 17'h047, ovf: 1'b0, cyc: cyc + 8});
    @(negedge clk);
    st_8 = 0;
    repeat (10) @(negedge clk);

    // DIGIT=2 vectors (Ovf compared when the option is built)
    st_2 = 1; a_2 = 8'h7F; b_2 = 8'h01; ci_2 = 0;
    @(posedge clk); #1;
    q2.push_back('{val: 17'h080, ovf: 1'b1, cyc: cyc + 4});
    a_2 = 8'hFF; b_2 = 8'h01;
    repeat (5) @(posedge clk); #1;
    q2.push_back('{val: 17'h100, ovf: 1'b0, cyc: cyc + 4});
    a_2 = 8'h80; b_2 = 8'h80;
    repeat (5) @(posedge clk); #1;
    q2.push_back('{val: 17'h100, ovf: 1'b1, cyc: cyc + 4});
    @(negedge clk);
    st_2 = 0;
    repeat (6) @(negedge clk);

    // WIDTH=4: all 512 {A,B,Cin} back-to-back with start held high
    {na, nb, nc} = 9'd0;
    st_4 = 1; a_4 = na; b_4 = nb; ci_4 = nc;
    for (int unsigned i = 0; i < 512; i++) begin
      if (i == 0) @(posedge clk);
      else repeat (5) @(posedge clk);
      #1;
      q4.push_back('{val: 17'(a_4) + 17'(b_4) + 17'(ci_4), ovf: 1'b0, cyc: cyc + 4});
      {na, nb, nc} = 9'(i + 1);
      a_4 = na; b_4 = nb; ci_4 = nc;
    end
    @(negedge clk);
    st_4 = 0;
    repeat (8) @(negedge clk);

    chk("q8 drained",  q8.size(),  0);
    chk("q4 drained",  q4.size(),  0);
    chk("q16 drained", q16.size(), 0);
    chk("qw drained",  qw.size(),  0);
    chk("q2 drained",  q2.size(),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
